// File: rtl/fsdct_pkg.sv
// fsdct_pkg: bank state type, DCT coefficient table generator and saturation helper.
package fsdct_pkg;

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

    typedef logic [63:0][15:0] coef_tab_t;

    function automatic longint cos_base(int a);
        case (a)
            0: return 64'sd1073741824;
            1: return 64'sd1053110176;
            2: return 64'sd992008094;
            3: return 64'sd892783698;
            4: return 64'sd759250125;
            5: return 64'sd596538995;
            6: return 64'sd410903207;
            7: return 64'sd209476638;
            default: return 64'sd0;
        endcase
    endfunction

    // cos(m*pi/16) in Q30, folded into the first quadrant
    function automatic longint cos_q30(int m);
        int a;
        longint s;
        a = (m <= 8) ? m : (m <= 16) ? 16 - m : (m <= 24) ? m - 16 : 32 - m;
        s = (m > 8 && m < 24) ? -64'sd1 : 64'sd1;
        return s * cos_base(a);
    endfunction

    // C(k,n) = round(2^sh * 0.5 * ck * cos((2n+1)k*pi/16)), half away from zero
    function automatic coef_tab_t coef_tab(int sh);
        coef_tab_t t;
        longint v;
        longint r;
        t = '0;
        for (int k = 0; k < 8; k++) begin
            for (int n = 0; n < 8; n++) begin
                v = (k == 0) ? cos_q30(4) : cos_q30(((2 * n + 1) * k) % 32);
                r = (v < 0) ? -((((-v) <<< sh) + (64'sd1 <<< 30)) >>> 31)
                            : (((v <<< sh) + (64'sd1 <<< 30)) >>> 31);
                t[k * 8 + n] = 16'(r);
            end
        end
        return t;
    endfunction

    function automatic longint sat(longint v, int w);
        longint mx;
        longint mn;
        mx = (64'sd1 <<< (w - 1)) - 64'sd1;
        mn = -mx - 64'sd1;
        return (v > mx) ? mx : (v < mn) ? mn : v;
    endfunction

endpackage

// File: rtl/fsdct_line8.sv
// fsdct_line8: combinational 8-point forward DCT with floor shift and signed saturation.
module fsdct_line8
    import fsdct_pkg::*;
#(
    parameter int IN_W  = 9,
    parameter int OUT_W = 16,
    parameter int SH    = 7
) (
    input  logic [7:0][IN_W-1:0]  x,
    output logic [7:0][OUT_W-1:0] y
);

    localparam coef_tab_t C = coef_tab(SH);

    longint acc;

    always_comb begin
        y   = '0;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            acc = 0;
            for (int n = 0; n < 8; n++)
                acc += longint'(signed'(x[n])) * longint'(signed'(C[k * 8 + n]));
            y[k] = OUT_W'(sat(acc >>> SH, OUT_W));
        end
    end

endmodule

// File: rtl/fsdct_stream2d.sv
// fsdct_stream2d: streaming 8x8 forward 2D DCT, row pass -> ping-pong transpose banks -> column pass.
// Define FSDCT_LEVEL_SHIFT_EN to subtract 2^(IW-1) from every input sample before the row pass.
module fsdct_stream2d
    import fsdct_pkg::*;
#(
    parameter int IW = 8,
    parameter int MW = 16,
    parameter int W  = 16,
    parameter int SH = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [8*IW-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [8*W-1:0]  out_data,
    output logic [2:0]      out_col,
    output logic            out_last
);

    localparam int XW = IW + 1;

    logic [7:0][XW-1:0]             row_x;
    logic [7:0][MW-1:0]             row_y;
    logic [7:0][MW-1:0]             col_x;
    logic [7:0][W-1:0]              col_y;
    logic [1:0][7:0][7:0][MW-1:0]   bank;
    bank_state_t [1:0]              bst;
    bank_state_t [1:0]              bst_n;
    logic                           wr_bank;
    logic                           rd_bank;
    logic [2:0]                     wr_row;
    logic [2:0]                     rd_col;
    logic                           wr_en;
    logic                           rd_en;

    always_comb begin
        row_x = '0;
        for (int i = 0; i < 8; i++)
`ifdef FSDCT_LEVEL_SHIFT_EN
            row_x[i] = {1'b0, in_data[i*IW +: IW]} - XW'(2 ** (IW - 1));
`else
            row_x[i] = {1'b0, in_data[i*IW +: IW]};
`endif
    end

    fsdct_line8 #(.IN_W(XW), .OUT_W(MW), .SH(SH)) u_row (.x(row_x), .y(row_y));

    always_comb begin
        col_x = '0;
        for (int r = 0; r < 8; r++)
            col_x[r] = bank[rd_bank][r][rd_col];
    end

    fsdct_line8 #(.IN_W(MW), .OUT_W(W), .SH(SH)) u_col (.x(col_x), .y(col_y));

    assign in_ready = bst[wr_bank] == EMPTY || bst[wr_bank] == FILLING;
    assign wr_en    = in_valid && in_ready;
    assign rd_en    = (bst[rd_bank] == FULL || bst[rd_bank] == DRAINING) && (!out_valid || out_ready);

    // write and read never target the same bank, so both updates can land in one cycle
    always_comb begin
        bst_n = bst;
        if (wr_en)
            bst_n[wr_bank] = (wr_row == 3'd7) ? FULL : FILLING;
        if (rd_en)
            bst_n[rd_bank] = (rd_col == 3'd7) ? EMPTY : DRAINING;
    end

    always_ff @(posedge clk)
        if (rst && wr_en)
            bank[wr_bank][wr_row] <= row_y;

    always_ff @(posedge clk) begin
        if (!rst) begin
            bst       <= '{EMPTY, EMPTY};
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_row    <= 3'd0;
            rd_col    <= 3'd0;
            out_valid <= 1'b0;
            out_col   <= 3'd0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            bst <= bst_n;
            if (wr_en) begin
                wr_row  <= wr_row + 3'd1;
                wr_bank <= wr_bank ^ (wr_row == 3'd7);
            end
            if (rd_en) begin
                out_data  <= col_y;
                out_col   <= rd_col;
                out_last  <= rd_col == 3'd7;
                out_valid <= 1'b1;
                rd_col    <= rd_col + 3'd1;
                rd_bank   <= rd_bank ^ (rd_col == 3'd7);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fsdct_stream2d.sv
// tb_fsdct_stream2d: table-driven constant blocks plus scoreboard against a real-valued DCT model.
module tb_fsdct_stream2d;

    localparam int IW = 8;
    localparam int MW = 16;
    localparam int W  = 16;
    localparam int SH = 7;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [63:0]    in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [127:0]   out_data;
    logic [2:0]     out_col;
    logic           out_last;

    always #5 clk = ~clk;

    fsdct_stream2d #(.IW(IW), .MW(MW), .W(W), .SH(SH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_col(out_col), .out_last(out_last)
    );

    typedef struct {
        logic [127:0] data;
        logic [2:0]   col;
        logic         last;
    } beat_t;

    typedef struct {
        logic [7:0]  v;
        logic [15:0] y00;
    } vec_t;

    typedef logic [7:0][7:0][7:0] blk_t;

    beat_t        q[$];
    int           ctab[8][8];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           stalls = 0;
    int           beat_cnt = 0;
    int           first_cyc = 0;
    int           last_cyc = 0;
    logic [127:0] beat0 = '0;
    beat_t        got;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic longint smp(logic [7:0] v);
`ifdef FSDCT_LEVEL_SHIFT_EN
        return longint'(v) - 128;
`else
        return longint'(v);
`endif
    endfunction

    function automatic longint clip(longint v, int w);
        longint mx = (64'sd1 <<< (w - 1)) - 1;
        return (v > mx) ? mx : (v < -mx - 1) ? -mx - 1 : v;
    endfunction

    task automatic push_model(input blk_t b);
        longint t[8][8];
        longint acc;
        beat_t  e;
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 8; k++) begin
                acc = 0;
                for (int n = 0; n < 8; n++) acc += ctab[k][n] * smp(b[r][n]);
                t[r][k] = clip(acc >>> SH, MW);
            end
        for (int c = 0; c < 8; c++) begin
            e.data = '0;
            for (int k = 0; k < 8; k++) begin
                acc = 0;
                for (int r = 0; r < 8; r++) acc += ctab[k][r] * t[r][c];
                e.data[k*W +: W] = W'(clip(acc >>> SH, W));
            end
            e.col  = 3'(c);
            e.last = (c == 7);
            q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", {125'd0, out_col}, 128'd8);
            end else begin
                got = q.pop_front();
                chk("beat_data", out_data, got.data);
                chk("beat_col", {125'd0, out_col}, {125'd0, got.col});
                chk("beat_last", {127'd0, out_last}, {127'd0, got.last});
                if (got.col == 3'd0) beat0 = out_data;
                beat_cnt++;
                if (beat_cnt == 1) first_cyc = cyc;
                last_cyc = cyc;
            end
        end
    end

    task automatic send_row(input logic [63:0] d);
        int   t = 0;
        logic rdy;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            @(negedge clk);
            rdy = in_ready;
            if (!rdy) stalls++;
            @(posedge clk);
            #1;
            t++;
        end while (!rdy && t < 200);
        if (!rdy) chk("row_accept_timeout", {127'd0, rdy}, 128'd1);
    endtask

    task automatic send_block(input blk_t b, input bit model);
        if (model) push_model(b);
        for (int r = 0; r < 8; r++) send_row(b[r]);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (q.size() != 0 && t < 400) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        chk("drain_left", 128'(q.size()), 128'd0);
    endtask

    vec_t  tbl[4];
    blk_t  b;
    beat_t e;
    real   cv;

    initial begin
        for (int k = 0; k < 8; k++)
            for (int n = 0; n < 8; n++) begin
                cv = (k == 0 ? 1.0 / $sqrt(2.0) : 1.0) * 64.0 * $cos((2 * n + 1) * k * 3.14159265358979 / 16.0);
                ctab[k][n] = (cv >= 0.0) ? int'($floor(cv + 0.5)) : -int'($floor(-cv + 0.5));
            end
`ifdef FSDCT_LEVEL_SHIFT_EN
        tbl[0] = '{8'd128, 16'd0};
        tbl[1] = '{8'd255, 16'd1004};
        tbl[2] = '{8'd0,   -16'sd1013};
        tbl[3] = '{8'd1,   -16'sd1007};
`else
        tbl[0] = '{8'd128, 16'd1012};
        tbl[1] = '{8'd255, 16'd2016};
        tbl[2] = '{8'd0,   16'd0};
        tbl[3] = '{8'd1,   16'd5};
`endif

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_out_col", {125'd0, out_col}, 128'd0);
        chk("rst_out_last", {127'd0, out_last}, 128'd0);
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        out_ready = 1'b1;

        // constant blocks: only DC survives
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) b[r][c] = tbl[i].v;
            for (int c = 0; c < 8; c++) begin
                e.data = (c == 0) ? {112'd0, tbl[i].y00} : 128'd0;
                e.col  = 3'(c);
                e.last = (c == 7);
                q.push_back(e);
            end
            send_block(b, 1'b0);
        end
        wait_drain();

        // impulse
        b = '0;
        b[0][0] = 8'd255;
        send_block(b, 1'b1);
        wait_drain();
`ifndef FSDCT_LEVEL_SHIFT_EN
        chk("impulse_y00", {112'd0, beat0[15:0]}, 128'd31);
`endif

        // back-to-back random blocks at full rate
        stalls   = 0;
        beat_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) b[r][c] = 8'($urandom_range(0, 255));
            send_block(b, 1'b1);
        end
        wait_drain();
        chk("b2b_stalls", 128'(stalls), 128'd0);
        chk("b2b_beats", 128'(beat_cnt), 128'd32);
        chk("b2b_span", 128'(last_cyc - first_cyc), 128'd31);

        // downstream stalled: two blocks fit, third row blocked, beat 0 held
        out_ready = 1'b0;
        stalls    = 0;
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) b[r][c] = 8'($urandom_range(0, 255));
            send_block(b, 1'b1);
        end
        chk("stall_16_rows_no_wait", 128'(stalls), 128'd0);
        in_valid = 1'b1;
        in_data  = 64'h0123456789abcdef;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {127'd0, in_ready}, 128'd0);
            chk("stall_out_valid", {127'd0, out_valid}, 128'd1);
            chk("stall_hold_data", out_data, q[0].data);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // reset mid-block discards partial rows
        for (int r = 0; r < 5; r++) send_row({8{8'hff}});
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("mid_rst_in_ready", {127'd0, in_ready}, 128'd1);
        @(posedge clk);
        #1;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) b[r][c] = 8'(r * 8 + c);
        send_block(b, 1'b1);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
